piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, is the parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 means bit 0 is sent first, 1 means bit WIDTH-1 is sent first.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: the reset is synchronous and active-low.
REQ-005 Port load_valid, input, 1 bit: message holds a word to serialise.
REQ-006 Port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 Port message, input, WIDTH bits: the parallel word, sampled only on load acceptance.
REQ-008 Port serial_out, output, 1 bit: the current serial bit.
REQ-009 Port serial_valid, output, 1 bit: serial_out carries a valid bit.
REQ-010 Port serial_ready, input, 1 bit: the downstream consumes serial_out this cycle.
REQ-011 Port frame_done, output, 1 bit: the bit on serial_out is the last bit of its word.

Function
REQ-012 Load acceptance SHALL occur on a rising edge where load_valid=1 and load_ready=1.
REQ-013 A bit transfer SHALL occur on a rising edge where serial_valid=1 and serial_ready=1.
REQ-014 The block SHALL have exactly two states: IDLE (serial_valid=0) and SHIFT (serial_valid=1).
REQ-015 load_ready SHALL be combinational: 1 in IDLE; in SHIFT, 1 only when frame_done=1 and serial_ready=1; otherwise 0.
REQ-016 On acceptance, the first bit of message SHALL appear on serial_out from the accepting edge onward, with serial_valid=1, giving one-cycle latency.
REQ-017 On acceptance, the remaining WIDTH-1 bits SHALL be stored internally and the bit counter SHALL be set to 0.
REQ-018 In SHIFT, each bit transfer that is not the last SHALL advance serial_out to the next bit in MSB_FIRST order and increment the bit counter by 1.
REQ-019 When serial_ready=0 in SHIFT, serial_out, serial_valid, frame_done and the bit counter SHALL hold their values (stall).
REQ-020 frame_done SHALL be 1 exactly while the WIDTH-th bit of a word is on serial_out, and 0 otherwise.
REQ-021 On a transfer of the last bit with no simultaneous acceptance, the block SHALL go to IDLE, with serial_valid=0, frame_done=0 and serial_out=0.
REQ-022 A transfer of the last bit together with an acceptance (back-to-back) SHALL present the first bit of the new word on the next cycle with no idle gap, and the block SHALL stay in SHIFT.
REQ-023 Each word SHALL produce exactly WIDTH bit transfers; there SHALL be no duplicated, dropped or padding bits.
REQ-024 In IDLE, serial_out SHALL be 0, and changes on message SHALL NOT affect any output.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-026 While reset_n=0 at a rising edge, the block SHALL enter IDLE and SHALL drive serial_out=0, serial_valid=0, frame_done=0, clear the bit counter and clear the stored word.
REQ-027 A reset asserted in the middle of a word SHALL discard the partial word; the first load after reset_n returns to 1 SHALL start a fresh word from bit 0.
REQ-028 load_ready SHALL be 1 in the first cycle after reset is released.
REQ-029 A load_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-030 With WIDTH=8, MSB_FIRST=0, serial_ready=1, load 8'b00001111 once: serial_out SHALL be 1,1,1,1,0,0,0,0 over 8 consecutive cycles, frame_done SHALL be high on the 8th bit only, and the block SHALL then be IDLE.
REQ-031 With WIDTH=8, MSB_FIRST=1, load 8'hA5: serial_out SHALL be 1,0,1,0,0,1,0,1.
REQ-032 With load_valid held at 1 and words 8'h0F then 8'hF0: 16 contiguous valid bits SHALL be produced with no gap, and load_ready SHALL pulse only on the cycle of each frame_done.
REQ-033 With serial_ready low for 3 cycles after the 2nd bit of 8'h3C: serial_out SHALL hold 0 for those 3 cycles, the full word SHALL still complete correctly, and message changes during the stall SHALL be ignored.
REQ-034 With reset_n=0 applied on the 4th bit of 8'hFF, then load 8'h01: the outputs SHALL reset in the cycle after that edge, and the next frame SHALL be 1,0,0,0,0,0,0,0.
REQ-035 With WIDTH=2 and WIDTH=13 in random stimulus: a scoreboard SHALL confirm that every accepted word is reproduced exactly.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with valid/ready on both sides.
// A word is accepted on load_valid & load_ready; its first bit is presented
// on serial_out the following cycle and each serial handshake advances one
// bit. A new word may be accepted on the same edge that the last bit of the
// current word is consumed, giving gap-free back-to-back frames.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; serial_valid=0, serial_out=0, load_ready=1
// SHIFT | a bit is on serial_out; load_ready only on last bit + serial_ready
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] message,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic accept;
    logic xfer;

    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = bit_q;
    assign frame_done   = done_q;
    // Ready in IDLE, or when the final bit is leaving this very cycle.
    assign load_ready   = (state_q == IDLE) || (done_q && serial_ready);
    assign accept       = load_valid && load_ready;
    assign xfer         = serial_valid && serial_ready;

    // Next-state: a load takes priority, since it can only coincide with the
    // final-bit transfer and then simply replaces the drained word.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            done_d  = 1'b0;
            if (MSB_FIRST) begin
                bit_d   = message[WIDTH-1];
                shreg_d = {message[WIDTH-2:0], 1'b0};
            end else begin
                bit_d   = message[0];
                shreg_d = {1'b0, message[WIDTH-1:1]};
            end
        end else if (xfer) begin
            if (done_q) begin
                state_d = IDLE;
                shreg_d = '0;
                bit_d   = 1'b0;
                cnt_d   = '0;
                done_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                done_d = (cnt_q == CW'(WIDTH - 2));
                if (MSB_FIRST) begin
                    bit_d   = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    bit_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
        end
    end

    // State register with synchronous active-low clear of everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four instances (8 LSB-first, 8 MSB-first,
// 2 LSB-first, 13 MSB-first). A negedge monitor keeps a per-instance queue
// of expected bits pushed at load acceptance and checks every handshake.
module tb_piso_serializer;

    localparam int N = 4;
    localparam int W_A[N] = '{8, 8, 2, 13};
    localparam bit M_A[N] = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct {
        bit b;
        bit last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        lv[N];
    logic        lr[N];
    logic        so[N];
    logic        sv[N];
    logic        sr[N];
    logic        fd[N];
    logic [63:0] msg[N];

    exp_t        sb[N][$];
    logic [63:0] cap[N];
    int          acc_cnt[N];
    int          vcyc[N];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = W_A[g];
        piso_serializer #(
            .WIDTH    (W),
            .MSB_FIRST(M_A[g])
        ) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .load_valid  (lv[g]),
            .load_ready  (lr[g]),
            .message     (msg[g][W-1:0]),
            .serial_out  (so[g]),
            .serial_valid(sv[g]),
            .serial_ready(sr[g]),
            .frame_done  (fd[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    // Monitor and reference model: the queue holds the bits still owed for
    // the current word (plus any next word), so its size alone tells whether
    // the block should be busy and whether the last bit is showing.
    always @(negedge clock) begin
        for (int g = 0; g < N; g++) begin
            bit   busy;
            bit   exp_lr;
            exp_t e;
            if (!reset_n) begin
                sb[g].delete();
            end else begin
                busy   = (sb[g].size() != 0);
                exp_lr = !busy || (sb[g].size() == 1 && sr[g]);
                if (sv[g]) vcyc[g]++;
                chk("serial_valid", g, sv[g], busy);
                chk("load_ready", g, lr[g], exp_lr);
                if (!busy) begin
                    chk("idle_serial_out", g, so[g], 0);
                    chk("idle_frame_done", g, fd[g], 0);
                end else begin
                    chk("serial_out", g, so[g], sb[g][0].b);
                    chk("frame_done", g, fd[g], sb[g][0].last);
                    if (sr[g]) begin
                        e = sb[g].pop_front();
                        cap[g] = {cap[g][62:0], so[g]};
                    end
                end
                if (lv[g] && exp_lr) begin
                    acc_cnt[g]++;
                    for (int i = 0; i < W_A[g]; i++) begin
                        int idx;
                        idx    = M_A[g] ? (W_A[g] - 1 - i) : i;
                        e.b    = msg[g][idx];
                        e.last = (i == W_A[g] - 1);
                        sb[g].push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int g);
        int k;
        k = 0;
        while (!(sv[g] == 1'b0 && sb[g].size() == 0) && k < 300) begin
            step();
            k++;
        end
        chk("wait_idle_timeout", g, (k >= 300), 0);
    endtask

    task automatic load_word(input int g, input logic [63:0] w);
        lv[g]  = 1'b1;
        msg[g] = w;
        step();
        lv[g]  = 1'b0;
        msg[g] = {$urandom, $urandom};
    endtask

    initial begin
        int base;
        int k;
        reset_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            lv[g] = 1'b0; sr[g] = 1'b1; msg[g] = '0;
            cap[g] = '0; acc_cnt[g] = 0; vcyc[g] = 0;
        end
        lv[0] = 1'b1;
        msg[0] = 64'hFF;
        repeat (3) step();
        // load_valid held through reset must not have been taken
        reset_n = 1'b1;
        lv[0] = 1'b0;
        chk("post_reset_valid", 0, sv[0], 0);
        chk("post_reset_ready", 0, lr[0], 1);
        step();
        chk("no_accept_in_reset", 0, sv[0], 0);

        // LSB-first single word
        cap[0] = '0; vcyc[0] = 0;
        load_word(0, 64'h0F);
        wait_idle(0);
        chk("lsb_0F_bits", 0, cap[0][7:0], 8'b11110000);
        chk("lsb_0F_valid_cycles", 0, vcyc[0], 8);

        // MSB-first single word
        cap[1] = '0;
        load_word(1, 64'hA5);
        wait_idle(1);
        chk("msb_A5_bits", 1, cap[1][7:0], 8'b10100101);

        // back-to-back with load_valid held high
        cap[0] = '0; vcyc[0] = 0;
        base = acc_cnt[0];
        lv[0] = 1'b1; msg[0] = 64'h0F;
        k = 0;
        while (acc_cnt[0] < base + 2 && k < 100) begin
            step();
            k++;
            if (acc_cnt[0] == base + 1) msg[0] = 64'hF0;
        end
        lv[0] = 1'b0;
        chk("b2b_accept_timeout", 0, (k >= 100), 0);
        wait_idle(0);
        chk("b2b_bits", 0, cap[0][15:0], 16'hF00F);
        chk("b2b_valid_cycles", 0, vcyc[0], 16);

        // stall on the second bit with message churning
        cap[0] = '0;
        load_word(0, 64'h3C);
        step();
        sr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_serial_out", 0, so[0], 0);
            chk("stall_valid", 0, sv[0], 1);
            msg[0] = {$urandom, $urandom};
            step();
        end
        sr[0] = 1'b1;
        wait_idle(0);
        chk("stall_3C_bits", 0, cap[0][7:0], 8'b00111100);

        // reset in mid-word, load offered during reset is ignored
        load_word(0, 64'hFF);
        repeat (3) step();
        chk("pre_reset_bit4", 0, so[0], 1);
        reset_n = 1'b0;
        lv[0] = 1'b1; msg[0] = 64'h55;
        step();
        chk("mid_reset_serial_out", 0, so[0], 0);
        chk("mid_reset_valid", 0, sv[0], 0);
        chk("mid_reset_frame_done", 0, fd[0], 0);
        reset_n = 1'b1;
        lv[0] = 1'b0;
        step();
        chk("after_reset_idle", 0, sv[0], 0);
        cap[0] = '0;
        load_word(0, 64'h01);
        wait_idle(0);
        chk("after_reset_01_bits", 0, cap[0][7:0], 8'b10000000);

        // random traffic on all instances, with occasional resets
        for (int g = 0; g < N; g++) acc_cnt[g] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < N; g++) begin
                lv[g]  = ($urandom_range(0, 3) != 0);
                sr[g]  = ($urandom_range(0, 3) != 0);
                msg[g] = {$urandom, $urandom};
            end
            reset_n = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1;
        for (int g = 0; g < N; g++) begin
            lv[g] = 1'b0;
            sr[g] = 1'b1;
        end
        for (int g = 0; g < N; g++) begin
            wait_idle(g);
            chk("drain_queue_empty", g, sb[g].size(), 0);
            chk("random_words_seen", g, (acc_cnt[g] > 10), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
